alu_driver: RTL and testbench

Multi-cycle initiator for the 32-bit datapath ALU. Accepts an operation command (MIPS ALUOp + funct, two operands) over a valid/ready handshake and decodes it to the 4-bit `ALUctl` code. It drives the ALU's `A`/`B`/`ALUctl` inputs, samples `ALUOut`/`Zero` after a fixed settle time, and returns the result over a second valid/ready handshake. It sits between the multi-cycle control FSM and the combinational `alu`, and owns the `ALUctl` side of that interface.

---
 rtl/alu_driver.sv | 169 ++++++++++++++++
 tb/tb_alu_driver.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_driver : multi-cycle initiator for the combinational 32-bit ALU.
//   Decodes ALUOp/funct to ALUctl and returns the result over valid/ready.
//   Optional overflow reporting: define ALU_OVF_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_driver #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_aluop,
  input  logic [5:0]       cmd_funct,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [3:0]       ALUctl,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic             Zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             rsp_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             dec_legal;
  logic [3:0]       dec_ctl;
  logic             ovf_calc;

  always_comb begin
    dec_legal = 1'b1;
    dec_ctl   = 4'd0;
    case (cmd_aluop)
      2'b00: dec_ctl = 4'd2;
      2'b01: dec_ctl = 4'd6;
      2'b10: begin
        case (cmd_funct)
          6'h20:   dec_ctl = 4'd2;
          6'h22:   dec_ctl = 4'd6;
          6'h24:   dec_ctl = 4'd0;
          6'h25:   dec_ctl = 4'd1;
          6'h2A:   dec_ctl = 4'd7;
          6'h27:   dec_ctl = 4'd12;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Overflow is judged against the operands actually held on the ALU inputs.
`ifdef ALU_OVF_EN
  always_comb begin
    ovf_calc = 1'b0;
    case (ctl_q)
      4'd2:    ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ALUOut[WIDTH-1] != a_q[WIDTH-1]);
      4'd6:    ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ALUOut[WIDTH-1] != a_q[WIDTH-1]);
      default: ovf_calc = 1'b0;
    endcase
  end
`else
  assign ovf_calc = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctl_d    = ctl_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (dec_legal) begin
            a_d     = cmd_a;
            b_d     = cmd_b;
            ctl_d   = dec_ctl;
            cnt_d   = LAT_CNT;
            state_d = HOLD;
          end else begin
            err_d    = 1'b1;
            result_d = '0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            state_d  = RESP;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d = ALUOut;
          zero_d   = Zero;
          ovf_d    = ovf_calc;
          err_d    = 1'b0;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ctl_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctl_q    <= ctl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign ALUctl     = ctl_q;
  assign A          = a_q;
  assign B          = b_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign rsp_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_driver : randomized and directed bench for alu_driver (LAT=1 and LAT=3).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_valid3, rsp_ready;
  logic [1:0]  cmd_aluop;
  logic [5:0]  cmd_funct;
  logic [31:0] cmd_a, cmd_b;

  logic        cmd_ready, rsp_valid, rsp_zero, rsp_err, rsp_ovf, zero;
  logic [3:0]  alu_ctl;
  logic [31:0] a_o, b_o, alu_out, rsp_result;

  logic        cmd_ready3, rsp_valid3, rsp_zero3, rsp_err3, rsp_ovf3, zero3;
  logic [3:0]  alu_ctl3;
  logic [31:0] a_o3, b_o3, alu_out3, rsp_result3;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model of what the ALU inputs should currently hold (last legal issue).
  logic [3:0]  m_ctl;
  logic [31:0] m_a, m_b;

  logic [5:0] legal_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_f(a_o, b_o, alu_ctl);
  assign zero     = (alu_out == 32'd0);
  assign alu_out3 = alu_f(a_o3, b_o3, alu_ctl3);
  assign zero3    = (alu_out3 == 32'd0);

  alu_driver #(.WIDTH(32), .LAT(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_aluop(cmd_aluop), .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ALUctl(alu_ctl), .A(a_o), .B(b_o), .ALUOut(alu_out), .Zero(zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ovf(rsp_ovf)
  );

  alu_driver #(.WIDTH(32), .LAT(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_aluop(cmd_aluop), .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ALUctl(alu_ctl3), .A(a_o3), .B(b_o3), .ALUOut(alu_out3), .Zero(zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_err(rsp_err3), .rsp_ovf(rsp_ovf3)
  );

  // Reference: what the command means, computed with plain signed arithmetic.
  function automatic void ref_cmd(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output bit legal, output logic [3:0] code,
                                  output logic [31:0] res, output bit ovf);
    longint s;
    int sa, sb;
    legal = 1'b1; code = 4'd0; res = 32'd0; ovf = 1'b0;
    sa = a; sb = b;
    case (op)
      2'd0: code = 4'd2;
      2'd1: code = 4'd6;
      2'd2: begin
        case (fn)
          6'h20: code = 4'd2;
          6'h22: code = 4'd6;
          6'h24: code = 4'd0;
          6'h25: code = 4'd1;
          6'h2A: code = 4'd7;
          6'h27: code = 4'd12;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      case (code)
        4'd2: begin
          s = longint'(sa) + longint'(sb);
          res = 32'(s);
          ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'd6: begin
          s = longint'(sa) - longint'(sb);
          res = 32'(s);
          ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'd0:    res = a & b;
        4'd1:    res = a | b;
        4'd7:    res = (sa < sb) ? 32'd1 : 32'd0;
        default: res = ~(a | b);
      endcase
    end
`ifndef ALU_OVF_EN
    ovf = 1'b0;
`endif
  endfunction

  // Issue one command to the LAT=1 instance; returns when rsp_valid is seen.
  // lat = clock edges after the accepting edge before rsp_valid is visible.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input bit early,
                        output int lat, output logic [3:0] ctl_s,
                        output logic [31:0] a_s, output logic [31:0] b_s);
    int w = 0;
    while (!cmd_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_ready_wait: got 0 want 1");
    end
    cmd_aluop = op; cmd_funct = fn; cmd_a = a; cmd_b = b;
    cmd_valid = 1'b1; rsp_ready = early;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ctl_s = alu_ctl; a_s = a_o; b_s = b_o;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b0;
    cmd_aluop = 2'd0; cmd_funct = 6'd0; cmd_a = 32'd0; cmd_b = 32'd0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    m_ctl = 4'd0; m_a = 32'd0; m_b = 32'd0;
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: got ready/valid %b want 10", {cmd_ready, rsp_valid});
    end
    n_cmp++;
    if ({alu_ctl, a_o, b_o} !== 68'd0) begin
      n_fail++; $display("FAIL reset_alu: got ctl %h A %h B %h want 0", alu_ctl, a_o, b_o);
    end
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_err, rsp_ovf} !== 35'd0) begin
      n_fail++; $display("FAIL reset_rsp: got %h z%b e%b o%b want 0", rsp_result, rsp_zero, rsp_err, rsp_ovf);
    end
  endtask

  task automatic test_add();
    int lat; logic [3:0] c; logic [31:0] sa, sb;
    do_cmd(2'b10, 6'h20, 32'd60, 32'd60, 1'b0, lat, c, sa, sb);
    n_cmp++;
    if (c !== 4'd2) begin n_fail++; $display("FAIL add_ctl: got %0d want 2", c); end
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL add_lat: got %0d want 1", lat); end
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_err} !== {32'd120, 2'b00}) begin
      n_fail++; $display("FAIL add_rsp: got %0d z%b e%b want 120 z0 e0", rsp_result, rsp_zero, rsp_err);
    end
    consume();
  endtask

  task automatic test_sub();
    int lat; logic [3:0] c; logic [31:0] sa, sb;
    do_cmd(2'b01, 6'h00, 32'd60, 32'd60, 1'b0, lat, c, sa, sb);
    n_cmp++;
    if (c !== 4'd6) begin n_fail++; $display("FAIL sub_ctl: got %0d want 6", c); end
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_err} !== {32'd0, 2'b10}) begin
      n_fail++; $display("FAIL sub_rsp: got %0d z%b e%b want 0 z1 e0", rsp_result, rsp_zero, rsp_err);
    end
    consume();
  endtask

  task automatic test_rtype_sweep();
    logic [5:0]  fn_t  [4] = '{6'h24, 6'h25, 6'h27, 6'h2A};
    logic [31:0] a_t   [4] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'd1};
    logic [31:0] b_t   [4] = '{32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'd2};
    logic [3:0]  ctl_t [4] = '{4'd0, 4'd1, 4'd12, 4'd7};
    logic [31:0] r_t   [4] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      int lat; logic [3:0] c; logic [31:0] sa, sb;
      do_cmd(2'b10, fn_t[i], a_t[i], b_t[i], 1'b0, lat, c, sa, sb);
      n_cmp++;
      if (c !== ctl_t[i]) begin
        n_fail++; $display("FAIL sweep_ctl[%0d]: got %0d want %0d", i, c, ctl_t[i]);
      end
      n_cmp++;
      if ({rsp_result, rsp_zero} !== {r_t[i], r_t[i] == 32'd0}) begin
        n_fail++; $display("FAIL sweep_res[%0d]: got %h z%b want %h", i, rsp_result, rsp_zero, r_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_illegal();
    int lat; logic [3:0] c; logic [31:0] sa, sb; bit stable = 1'b1;
    do_cmd(2'b10, 6'h3F, 32'hDEADBEEF, 32'h12345678, 1'b0, lat, c, sa, sb);
    n_cmp++;
    if (lat !== 0) begin n_fail++; $display("FAIL ill_lat: got %0d want 0", lat); end
    n_cmp++;
    if ({rsp_err, rsp_result, rsp_zero, rsp_ovf} !== {1'b1, 32'd0, 2'b00}) begin
      n_fail++; $display("FAIL ill_rsp: got e%b %h z%b o%b want e1 0", rsp_err, rsp_result, rsp_zero, rsp_ovf);
    end
    n_cmp++;
    if ({c, sa, sb} !== {4'd7, 32'd1, 32'd2}) begin
      n_fail++; $display("FAIL ill_alu: got ctl %0d A %h B %h want 7 1 2", c, sa, sb);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (!(rsp_valid && !cmd_ready && rsp_err && rsp_result == 32'd0 &&
            alu_ctl == 4'd7 && a_o == 32'd1 && b_o == 32'd2)) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL ill_hold: got unstable want stable"); end
    consume();
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL ill_done: got %b want 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      int lat; logic [3:0] c; logic [31:0] sa, sb;
      do_cmd(2'b00, 6'h00, 32'd3 + 32'(i), 32'd4, 1'b1, lat, c, sa, sb);
      n_cmp++;
      if ({lat == 1, rsp_result} !== {1'b1, 32'd7 + 32'(i)}) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got lat %0d res %0d want 1 %0d", i, lat, rsp_result, 7 + i);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_cmp++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
        n_fail++; $display("FAIL b2b_idle[%0d]: got %b want 10", i, {cmd_ready, rsp_valid});
      end
    end
  endtask

  task automatic test_overflow();
    int lat; logic [3:0] c; logic [31:0] sa, sb; bit exp_o;
`ifdef ALU_OVF_EN
    exp_o = 1'b1;
`else
    exp_o = 1'b0;
`endif
    do_cmd(2'b00, 6'h00, 32'h7FFFFFFF, 32'd1, 1'b0, lat, c, sa, sb);
    n_cmp++;
    if ({rsp_result, rsp_ovf} !== {32'h80000000, exp_o}) begin
      n_fail++; $display("FAIL ovf_add: got %h o%b want 80000000 o%b", rsp_result, rsp_ovf, exp_o);
    end
    consume();
    do_cmd(2'b01, 6'h00, 32'h80000000, 32'd1, 1'b0, lat, c, sa, sb);
    n_cmp++;
    if ({rsp_result, rsp_ovf} !== {32'h7FFFFFFF, exp_o}) begin
      n_fail++; $display("FAIL ovf_sub: got %h o%b want 7fffffff o%b", rsp_result, rsp_ovf, exp_o);
    end
    consume();
    do_cmd(2'b00, 6'h00, 32'hFFFFFFFF, 32'd1, 1'b0, lat, c, sa, sb);
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_ovf} !== {32'd0, 2'b10}) begin
      n_fail++; $display("FAIL ovf_none: got %h z%b o%b want 0 z1 o0", rsp_result, rsp_zero, rsp_ovf);
    end
    consume();
  endtask

  task automatic test_abort();
    int lat; bit quiet = 1'b1;
    cmd_aluop = 2'b00; cmd_funct = 6'h00; cmd_a = 32'd5; cmd_b = 32'd6;
    cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ctl = 4'd0; m_a = 32'd0; m_b = 32'd0;
    n_cmp++;
    if ({cmd_ready3, rsp_valid3, alu_ctl3, a_o3, b_o3, rsp_result3, rsp_zero3, rsp_err3, rsp_ovf3}
        !== {2'b10, 103'd0}) begin
      n_fail++; $display("FAIL abort_state: got rdy%b vld%b ctl %0d A %h res %h want reset values",
                         cmd_ready3, rsp_valid3, alu_ctl3, a_o3, rsp_result3);
    end
    repeat (4) begin @(posedge clk); #1; if (rsp_valid3) quiet = 1'b0; end
    n_cmp++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL abort_quiet: got rsp_valid want none"); end
    cmd_aluop = 2'b01; cmd_a = 32'd9; cmd_b = 32'd4;
    cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if ({lat == 3, rsp_result3, rsp_zero3, rsp_err3} !== {1'b1, 32'd5, 2'b00}) begin
      n_fail++; $display("FAIL lat3_cmd: got lat %0d res %0d want 3 5", lat, rsp_result3);
    end
    consume();
    n_cmp++;
    if ({cmd_ready3, rsp_valid3} !== 2'b10) begin
      n_fail++; $display("FAIL lat3_done: got %b want 10", {cmd_ready3, rsp_valid3});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op; logic [5:0] fn; logic [31:0] a, b, res; logic [3:0] code;
      bit legal, ovf, early, busy = 1'b1;
      int lat; logic [3:0] c; logic [31:0] sa, sb;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
      a  = ($urandom_range(0, 4) == 0) ? 32'h7FFFFFFF : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      early = 1'($urandom_range(0, 1));
      ref_cmd(op, fn, a, b, legal, code, res, ovf);
      do_cmd(op, fn, a, b, early, lat, c, sa, sb);
      if (legal) begin m_ctl = code; m_a = a; m_b = b; end
      n_cmp++;
      if ({lat, c, sa, sb} !== {(legal ? 32'd1 : 32'd0), m_ctl, m_a, m_b}) begin
        n_fail++; $display("FAIL rnd_issue[%0d]: got lat %0d ctl %0d A %h B %h want %0d %0d %h %h",
                           i, lat, c, sa, sb, legal, m_ctl, m_a, m_b);
      end
      n_cmp++;
      if ({rsp_result, rsp_zero, rsp_err, rsp_ovf} !== {res, legal && res == 32'd0, !legal, ovf}) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got %h z%b e%b o%b want %h z%b e%b o%b", i,
                           rsp_result, rsp_zero, rsp_err, rsp_ovf, res, legal && res == 32'd0, !legal, ovf);
      end
      if (early) begin
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          if (!(rsp_valid && !cmd_ready && rsp_result == res)) busy = 1'b0;
        end
        consume();
      end
      n_cmp++;
      if ({busy, cmd_ready, rsp_valid} !== 3'b110) begin
        n_fail++; $display("FAIL rnd_hs[%0d]: got hold%b rdy%b vld%b want 1 1 0", i, busy, cmd_ready, rsp_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_rtype_sweep();
    test_illegal();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
